// File: rtl/alu_pkg.sv
// Shared decode constants, FSM state type and a small decode helper for the
// alu_issue issue/writeback stage.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'h1;
  localparam logic [2:0] F3_SRX = 3'h5;

  typedef enum logic {
    IDLE,
    EXECUTE
  } state_t;

  // Shift encodings take their rhs as a 5-bit shift amount and carry a
  // meaningful upper field (funct7 / imm[11:5]) into the ALU metadata.
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SRX);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake bundle: the producer drives instr/instr_valid and
// the issue stage answers with instr_ready.
interface alu_issue_if;

  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/regfile.sv
// Architectural register file: three asynchronous read ports (rs1, rs2,
// debug) and one synchronous write port. x0 is never written, so it reads 0.
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] dbg_data,
  input  logic                  we,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] regs_reg [REG_COUNT];

  // Clear every register on reset; afterwards commit writes except to x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we && (wr_addr != 5'd0)) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = regs_reg[rs1_addr];
  assign rs2_data = regs_reg[rs2_addr];
  assign dbg_data = regs_reg[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue and writeback stage around an external RV32I ALU. Accepts one
// instruction per two cycles, decodes OP / OP-IMM, presents registered
// operands to the ALU, then retires the ALU result or flags the
// instruction as illegal in the following cycle.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_if.slave            in_if,
  output logic [DATA_WIDTH-1:0] alu_lhs,
  output logic                  alu_lhs_valid,
  output logic [DATA_WIDTH-1:0] alu_rhs,
  output logic                  alu_rhs_valid,
  output logic [2:0]            alu_operation,
  output logic                  alu_operation_valid,
  output logic [6:0]            alu_metadata,
  output logic                  alu_metadata_valid,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_result_valid,
  output logic                  retire_valid,
  output logic [4:0]            retire_rd,
  output logic [DATA_WIDTH-1:0] retire_data,
  output logic                  illegal,
  input  logic [4:0]            dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  state_t state_reg;
  state_t state_next;

  logic accept;
  logic instr_ready;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = in_if.instr[6:0];
  assign rd     = in_if.instr[11:7];
  assign funct3 = in_if.instr[14:12];
  assign rs1    = in_if.instr[19:15];
  assign rs2    = in_if.instr[24:20];
  assign funct7 = in_if.instr[31:25];

  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;
  logic [DATA_WIDTH-1:0] imm_sext;

  assign imm_sext = {{(DATA_WIDTH-12){in_if.instr[31]}}, in_if.instr[31:20]};

  // Decoded operands, captured on the handshake edge
  logic                  dec_alu;
  logic [DATA_WIDTH-1:0] dec_lhs;
  logic [DATA_WIDTH-1:0] dec_rhs_raw;
  logic [DATA_WIDTH-1:0] dec_rhs;
  logic [2:0]            dec_op;
  logic [6:0]            dec_meta;

  // Registered ALU-facing state for the EXECUTE cycle
  logic                  alu_valid_reg;
  logic [DATA_WIDTH-1:0] lhs_reg;
  logic [DATA_WIDTH-1:0] rhs_reg;
  logic [2:0]            op_reg;
  logic [6:0]            meta_reg;
  logic [4:0]            rd_reg;

  logic rf_we;

  regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wr_addr  (rd_reg),
    .wr_data  (alu_result)
  );

  // Decode OP / OP-IMM into ALU operands; anything else decodes to zeros.
  always_comb begin
    dec_alu     = (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
    dec_lhs     = '0;
    dec_rhs_raw = '0;
    dec_rhs     = '0;
    dec_op      = '0;
    dec_meta    = '0;
    if (dec_alu) begin
      dec_lhs = rs1_data;
      dec_op  = funct3;
      if (opcode == OPC_OP) begin
        dec_rhs_raw = rs2_data;
        dec_meta    = funct7;
      end else begin
        dec_rhs_raw = imm_sext;
        if (is_shift(funct3)) begin
          dec_meta = funct7;
        end
      end
      // Shift amounts are the low five bits only, zero-extended.
      if (is_shift(funct3)) begin
        dec_rhs = {{(DATA_WIDTH-5){1'b0}}, dec_rhs_raw[4:0]};
      end else begin
        dec_rhs = dec_rhs_raw;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus handshake and retire/illegal pulses.
  always_comb begin
    state_next   = state_reg;
    instr_ready  = 1'b0;
    accept       = 1'b0;
    retire_valid = 1'b0;
    illegal      = 1'b0;
    case (state_reg)
      IDLE: begin
        // Held low while reset is asserted so nothing is offered upstream.
        instr_ready = rst_n;
        accept      = in_if.instr_valid && instr_ready;
        if (accept) begin
          state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        state_next = IDLE;
        if (alu_valid_reg && alu_result_valid) begin
          retire_valid = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_if.instr_ready = instr_ready;

  // Capture decoded operands on accept; clear them when leaving EXECUTE so
  // the ALU bus reads all zeros while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_valid_reg <= 1'b0;
      lhs_reg       <= '0;
      rhs_reg       <= '0;
      op_reg        <= '0;
      meta_reg      <= '0;
      rd_reg        <= '0;
    end else if (accept) begin
      alu_valid_reg <= dec_alu;
      lhs_reg       <= dec_lhs;
      rhs_reg       <= dec_rhs;
      op_reg        <= dec_op;
      meta_reg      <= dec_meta;
      rd_reg        <= rd;
    end else if (state_reg == EXECUTE) begin
      alu_valid_reg <= 1'b0;
      lhs_reg       <= '0;
      rhs_reg       <= '0;
      op_reg        <= '0;
      meta_reg      <= '0;
      rd_reg        <= '0;
    end
  end

  assign alu_lhs             = lhs_reg;
  assign alu_rhs             = rhs_reg;
  assign alu_operation       = op_reg;
  assign alu_metadata        = meta_reg;
  assign alu_lhs_valid       = alu_valid_reg;
  assign alu_rhs_valid       = alu_valid_reg;
  assign alu_operation_valid = alu_valid_reg;
  assign alu_metadata_valid  = alu_valid_reg;

  assign rf_we       = retire_valid;
  assign retire_rd   = retire_valid ? rd_reg : 5'd0;
  assign retire_data = (retire_valid && (rd_reg != 5'd0)) ? alu_result : '0;

endmodule
